dma_bus_arbiter: RTL

Round-robin bus arbiter that shares the single system bus between up to NUM_MASTERS bus masters (CPU instruction/data ports, ramDmaCi DMA engines, display/camera masters). It takes each master's transaction request, issues a one-hot registered grant, and tracks the granted transaction from begin to end. It releases the bus one cycle after end, then moves priority to the next master. An optional watchdog forcibly terminates a stalled transaction.

---
 rtl/dma_bus_pkg.sv | 15 +
 rtl/dma_bus_arbiter_if.sv | 28 ++
 rtl/rr_priority_pick.sv | 34 +++
 rtl/dma_bus_arbiter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/dma_bus_pkg.sv
// Shared types and constants for the DMA system-bus arbiter.
package dma_bus_pkg;

    localparam int unsigned MAX_MASTERS = 8;
    localparam int unsigned IDX_W       = 3;
    localparam int unsigned WDOG_W      = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/dma_bus_arbiter_if.sv
// Request/grant and transaction-framing signals between bus masters and the arbiter.
interface dma_bus_arbiter_if
    import dma_bus_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4
);

    logic [NUM_MASTERS-1:0] request;
    logic [NUM_MASTERS-1:0] grant;
    logic                   begin_transaction_in;
    logic                   end_transaction_in;
    logic                   bus_error_in;
    logic                   end_transaction_out;
    logic                   bus_error_out;
    logic [IDX_W-1:0]       active_master;
    logic                   bus_busy;

    modport master (
        output request, begin_transaction_in, end_transaction_in, bus_error_in,
        input  grant, end_transaction_out, bus_error_out, active_master, bus_busy
    );

    modport slave (
        input  request, begin_transaction_in, end_transaction_in, bus_error_in,
        output grant, end_transaction_out, bus_error_out, active_master, bus_busy
    );

endinterface

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first set request at or above the pointer, wrapping around.
module rr_priority_pick
    import dma_bus_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]       i_ptr,
    output logic [NUM_MASTERS-1:0] o_pick_c,
    output logic [IDX_W-1:0]       o_idx_c,
    output logic                   o_valid_c
);

    localparam int unsigned DW = 2 * NUM_MASTERS;

    logic [DW-1:0] w_masked;

    // Upper copy covers the wrap, so the lowest surviving bit is the winner.
    always_comb begin
        w_masked  = {i_req, i_req} & ({DW{1'b1}} << i_ptr);
        o_idx_c   = '0;
        o_valid_c = 1'b0;
        for (int unsigned i = 0; i < DW; i++) begin
            if (w_masked[i] && !o_valid_c) begin
                o_valid_c = 1'b1;
                o_idx_c   = IDX_W'(i % NUM_MASTERS);
            end
        end
        for (int unsigned j = 0; j < NUM_MASTERS; j++) begin
            o_pick_c[j] = o_valid_c && (o_idx_c == IDX_W'(j));
        end
    end

endmodule

// File: rtl/dma_bus_arbiter.sv
// Round-robin system-bus arbiter with transaction tracking.
// Optional stall watchdog enabled by defining ARBITER_WATCHDOG_EN.
module dma_bus_arbiter
    import dma_bus_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    dma_bus_arbiter_if.slave bus
);

    if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS) begin : g_bad_num_masters
        $error("dma_bus_arbiter: NUM_MASTERS out of range");
    end
    if (TIMEOUT_CYCLES < 16 || TIMEOUT_CYCLES > (1 << WDOG_W) - 1) begin : g_bad_timeout
        $error("dma_bus_arbiter: TIMEOUT_CYCLES out of range");
    end

    arb_state_e             r_state, w_state_nxt;
    logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
    logic [IDX_W-1:0]       r_active, w_active_nxt;
    logic [IDX_W-1:0]       r_ptr, w_ptr_nxt;
    logic                   r_busy, w_busy_nxt;
    logic [NUM_MASTERS-1:0] w_pick;
    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_pick_valid;
    logic                   w_owner_req;
    logic                   w_force_end;
    logic                   w_unused_bus_error;

    rr_priority_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
        .i_req     (bus.request),
        .i_ptr     (r_ptr),
        .o_pick_c  (w_pick),
        .o_idx_c   (w_pick_idx),
        .o_valid_c (w_pick_valid)
    );

    assign w_owner_req        = |(bus.request & r_grant);
    // A bus error alone never moves the FSM; only the end strobe closes a transaction.
    assign w_unused_bus_error = bus.bus_error_in;

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_active_nxt = r_active;
        w_ptr_nxt    = r_ptr;
        w_busy_nxt   = r_busy;
        unique case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_grant_nxt  = w_pick;
                    w_active_nxt = w_pick_idx;
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = GRANT;
                end
            end
            GRANT: begin
                if (w_force_end) begin
                    w_state_nxt = RELEASE;
                end else if (bus.begin_transaction_in) begin
                    w_state_nxt = BUSY;
                end else if (!w_owner_req) begin
                    // Abandoned grant: pointer stays so the same master keeps priority.
                    w_grant_nxt  = '0;
                    w_active_nxt = '0;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = IDLE;
                end
            end
            BUSY: begin
                if (bus.end_transaction_in || w_force_end) begin
                    w_state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                w_grant_nxt  = '0;
                w_active_nxt = '0;
                w_busy_nxt   = 1'b0;
                w_ptr_nxt    = (r_active == IDX_W'(NUM_MASTERS - 1)) ? '0 : r_active + IDX_W'(1);
                w_state_nxt  = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_active <= '0;
            r_ptr    <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_active <= w_active_nxt;
            r_ptr    <= w_ptr_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

`ifdef ARBITER_WATCHDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [WDOG_W-1:0] r_wdog_cnt, w_wdog_cnt_nxt;
    logic              r_end_out;
    logic              r_err_out;

    // Counter is zero on GRANT entry; expiry lands the pulses together with RELEASE.
    always_comb begin
        w_wdog_cnt_nxt = r_wdog_cnt;
        if (r_state == IDLE) begin
            w_wdog_cnt_nxt = '0;
        end else if (r_state == GRANT || r_state == BUSY) begin
            w_wdog_cnt_nxt = r_wdog_cnt + WDOG_W'(1);
        end
    end

    assign w_force_end = (r_wdog_cnt == WDOG_LAST) &&
                         ((r_state == GRANT) || (r_state == BUSY && !bus.end_transaction_in));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wdog_cnt <= '0;
            r_end_out  <= 1'b0;
            r_err_out  <= 1'b0;
        end else begin
            r_wdog_cnt <= w_wdog_cnt_nxt;
            r_end_out  <= w_force_end;
            r_err_out  <= w_force_end;
        end
    end

    assign bus.end_transaction_out = r_end_out;
    assign bus.bus_error_out       = r_err_out;
`else
    assign w_force_end             = 1'b0;
    assign bus.end_transaction_out = 1'b0;
    assign bus.bus_error_out       = 1'b0;
`endif

    assign bus.grant         = r_grant;
    assign bus.active_master = r_active;
    assign bus.bus_busy      = r_busy;

endmodule
